// File: rtl/pdet_pkg.sv
// -----------------------------------------------------------------------------
// pdet_pkg
//
// Purpose : Shared constants for the pdet rising-edge detector. This package
//           holds the default values of the detector's parameters. The
//           interface, the synchronizer and the top all take their defaults
//           from here, so the defaults are defined once.
//
// Contents: PDET_DEF_WIDTH       - default number of independent channels
//           PDET_DEF_SYNC_STAGES - default synchronizer depth (0 = none)
//           PDET_DEF_REG_OUT     - default output mode (0 = combinational)
// -----------------------------------------------------------------------------
package pdet_pkg;

    // One channel. The input is already synchronous and the output is
    // combinational.
    localparam int unsigned PDET_DEF_WIDTH       = 1;
    localparam int unsigned PDET_DEF_SYNC_STAGES = 0;
    localparam int unsigned PDET_DEF_REG_OUT     = 0;

endpackage : pdet_pkg

// File: rtl/pdet_if.sv
// -----------------------------------------------------------------------------
// pdet_if
//
// Purpose : Signal bundle between a level source and the pdet edge detector.
//
// Signals : d      [WIDTH] - level inputs to monitor, one detector per bit
//           p_edge [WIDTH] - per-channel rising-edge pulse
//
// Modports: master - the level source; drives d and observes p_edge
//           slave  - the detector; observes d and drives p_edge
// -----------------------------------------------------------------------------
interface pdet_if
    import pdet_pkg::*;
#(
    parameter int unsigned WIDTH = PDET_DEF_WIDTH
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] p_edge;

    modport master (
        output d,
        input  p_edge
    );

    modport slave (
        input  d,
        output p_edge
    );

endinterface : pdet_if

// File: rtl/pdet_sync_ff.sv
// -----------------------------------------------------------------------------
// pdet_sync_ff
//
// Purpose : Flop chain, WIDTH bits wide and STAGES flops deep, with an
//           asynchronous active-low clear. It brings level inputs that may be
//           asynchronous into the clk domain before edge detection. Each bit
//           is synchronized on its own. Channels that change together at the
//           input can therefore come out one cycle apart. For independent
//           channels this is acceptable.
//
// Ports   : clk  - rising-edge clock
//           rstn - asynchronous active-low clear of every stage
//           i_d  [WIDTH] - raw level input
//           o_q  [WIDTH] - synchronized level (output of the last stage)
// -----------------------------------------------------------------------------
module pdet_sync_ff
    import pdet_pkg::*;
#(
    parameter int unsigned WIDTH  = PDET_DEF_WIDTH,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // r_stage[0] captures the raw input. r_stage[STAGES-1] is the settled
    // output.
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // NOTE: reset is in the sensitivity list, so the clear takes effect
    // immediately and does not wait for a clock. Inside a clocked block every
    // state update uses <=. All flops then sample their pre-edge values
    // together, which is what makes the chain shift by exactly one stage per
    // edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule : pdet_sync_ff

// File: rtl/pdet.sv
// -----------------------------------------------------------------------------
// pdet
//
// Purpose : Rising-edge detector for WIDTH independent level signals. A
//           channel's p_edge pulses for one clock period when its level goes
//           from 0 to 1. A steady level produces no pulse, and neither does a
//           falling edge.
//
// Parameters:
//   WIDTH       - number of independent channels
//   SYNC_STAGES - flop stages placed ahead of the detector. 0 means the input
//                 is already synchronous to clk. Use 2 or more for
//                 asynchronous inputs.
//   REG_OUT     - 0: p_edge is combinational (zero latency; the pulse lasts
//                    until the next edge and is at most one period wide).
//                 1: p_edge is registered (a clean one-cycle pulse, one cycle
//                    later).
//
// Ports   : clk  - rising-edge clock
//           rstn - asynchronous active-low reset; clears every flop and
//                  forces p_edge to 0 in both output modes
//           bus  - pdet_if slave modport: d (levels in), p_edge (pulses out)
//
// Total latency from d to p_edge is SYNC_STAGES cycles, plus one cycle when
// REG_OUT=1. Because the delayed sample clears to 0, a level that is already
// high when reset releases is reported as a rising edge.
// -----------------------------------------------------------------------------
module pdet
    import pdet_pkg::*;
#(
    parameter int unsigned WIDTH       = PDET_DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = PDET_DEF_SYNC_STAGES,
    parameter int unsigned REG_OUT     = PDET_DEF_REG_OUT
) (
    input  logic   clk,
    input  logic   rstn,
    pdet_if.slave  bus
);

    logic [WIDTH-1:0] w_s;      // detector input: d, or the synchronized d
    logic [WIDTH-1:0] r_d_q;    // w_s as sampled on the previous clock edge
    logic [WIDTH-1:0] w_rise;   // current-sample 0->1 transitions

    // ---------------------------------------------------------------------
    // Optional input synchronizer
    // ---------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            pdet_sync_ff #(
                .WIDTH  (WIDTH),
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rstn (rstn),
                .i_d  (bus.d),
                .o_q  (w_s)
            );
        end else begin : g_nosync
            assign w_s = bus.d;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Delayed sample and edge term
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_d_q <= '0;
        end else begin
            r_d_q <= w_s;
        end
    end

    assign w_rise = w_s & ~r_d_q;

    // ---------------------------------------------------------------------
    // Output stage
    // ---------------------------------------------------------------------
    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_p_edge;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_p_edge <= '0;
                end else begin
                    r_p_edge <= w_rise;
                end
            end

            assign bus.p_edge = r_p_edge;
        end else begin : g_comb_out
            // NOTE: w_s comes straight from d when there is no synchronizer.
            // A high d during reset would then show as a rising edge even
            // though every flop is held clear. Gating with rstn keeps the
            // output at 0 for the whole reset.
            assign bus.p_edge = w_rise & {WIDTH{rstn}};
        end
    endgenerate

endmodule : pdet

// File: tb/tb_pdet.sv
// -----------------------------------------------------------------------------
// tb_pdet
//
// Drives five pdet instances from one shared 4-bit level stimulus:
//   u0 : defaults (WIDTH=1, SYNC_STAGES=0, REG_OUT=0), fed from bit 0
//   u1 : WIDTH=4, SYNC_STAGES=2, REG_OUT=1
//   u2 : WIDTH=4, SYNC_STAGES=0, REG_OUT=0
//   u3 : WIDTH=4, SYNC_STAGES=1, REG_OUT=0
//   u4 : WIDTH=4, SYNC_STAGES=0, REG_OUT=1
// The reference model keeps a history of d as sampled on each rising edge
// since reset (hist[0] = most recent). From that history:
//   input seen by the detector now   = d (no sync) or the d of SYNC edges ago
//   previous detector sample         = the d of SYNC+1 edges ago
//   combinational pulse              = now & ~previous
//   registered pulse                 = the combinational pulse that held just
//                                      before the last edge
// -----------------------------------------------------------------------------
module tb_pdet;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] drv_d;

    always #5 clk = ~clk;

    pdet_if #(.WIDTH(1)) if0 ();
    pdet_if #(.WIDTH(4)) if1 ();
    pdet_if #(.WIDTH(4)) if2 ();
    pdet_if #(.WIDTH(4)) if3 ();
    pdet_if #(.WIDTH(4)) if4 ();

    assign if0.d = drv_d[0];
    assign if1.d = drv_d;
    assign if2.d = drv_d;
    assign if3.d = drv_d;
    assign if4.d = drv_d;

    pdet u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    pdet #(.WIDTH(4), .SYNC_STAGES(2), .REG_OUT(1)) u1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
    pdet #(.WIDTH(4), .SYNC_STAGES(0), .REG_OUT(0)) u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
    pdet #(.WIDTH(4), .SYNC_STAGES(1), .REG_OUT(0)) u3 (.clk(clk), .rstn(rstn), .bus(if3.slave));
    pdet #(.WIDTH(4), .SYNC_STAGES(0), .REG_OUT(1)) u4 (.clk(clk), .rstn(rstn), .bus(if4.slave));

    // ---------------------------------------------------------------------
    // Reference model: per-edge sample history since the last reset
    // ---------------------------------------------------------------------
    logic [3:0] hist [0:7];
    int         n_pass  = 0;
    int         n_total = 0;

    function automatic logic [3:0] expect_pe(input int sync, input int reg_out);
        logic [3:0] now_v;
        if (rstn !== 1'b1) return 4'h0;
        if (reg_out == 0) begin
            now_v = (sync == 0) ? drv_d : hist[sync-1];
            return now_v & ~hist[sync];
        end
        return hist[sync] & ~hist[sync+1];
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 8; i++) hist[i] = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp_v);
    endtask

    task automatic check_all(input string when);
        chk({when, " u0_def"},   {3'b000, if0.p_edge}, expect_pe(0, 0) & 4'h1);
        chk({when, " u1_s2r1"},  if1.p_edge,           expect_pe(2, 1));
        chk({when, " u2_s0r0"},  if2.p_edge,           expect_pe(0, 0));
        chk({when, " u3_s1r0"},  if3.p_edge,           expect_pe(1, 0));
        chk({when, " u4_s0r1"},  if4.p_edge,           expect_pe(0, 1));
    endtask

    // One clock cycle: take the edge, check after it, change the inputs
    // between edges, then check again while the new level is applied.
    task automatic cyc(input logic [3:0] nd, input logic nrst);
        @(posedge clk);
        if (rstn === 1'b1) begin
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = drv_d;
        end
        #2 check_all("post_edge");
        #2;
        drv_d = nd;
        rstn  = nrst;
        if (!nrst) clear_hist();
        #3 check_all("post_drive");
    endtask

    // Assert reset late in the low phase, while a pulse may still be showing.
    task automatic rst_mid();
        #1 rstn = 1'b0;
        clear_hist();
        #1 check_all("mid_reset");
    endtask

    initial begin
        clear_hist();
        // Reset held with d high: no pulse anywhere.
        rstn  = 1'b0;
        drv_d = 4'hF;
        #1 check_all("in_reset");
        repeat (3) cyc(4'hF, 1'b0);
        // Release with d high: the high level counts as a rising edge.
        cyc(4'hF, 1'b1);
        repeat (4) cyc(4'hF, 1'b1);
        // Fall only.
        repeat (3) cyc(4'h0, 1'b1);
        // Single rise held for 4 cycles.
        repeat (4) cyc(4'h1, 1'b1);
        repeat (3) cyc(4'h0, 1'b1);
        // Short high, gap, high again.
        cyc(4'h1, 1'b1);
        cyc(4'h0, 1'b1);
        cyc(4'h0, 1'b1);
        cyc(4'h1, 1'b1);
        repeat (4) cyc(4'h0, 1'b1);
        // Back-to-back toggling.
        repeat (3) begin
            cyc(4'hF, 1'b1);
            cyc(4'h0, 1'b1);
        end
        repeat (3) cyc(4'h0, 1'b1);
        // Multi-channel: 0000 -> 0101 -> 1111.
        cyc(4'h5, 1'b1);
        cyc(4'hF, 1'b1);
        repeat (5) cyc(4'hF, 1'b1);
        // Reset mid-pulse on the combinational output.
        repeat (3) cyc(4'h0, 1'b1);
        cyc(4'hF, 1'b1);
        rst_mid();
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b1);
        // Reset mid-pulse on the registered output.
        repeat (3) cyc(4'h0, 1'b1);
        cyc(4'hF, 1'b1);
        cyc(4'hF, 1'b1);
        rst_mid();
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b1);
        // Randomized levels, with held runs and occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] nd;
            logic       nr;
            nd = ($urandom_range(0, 2) == 0) ? drv_d : 4'($urandom);
            nr = ($urandom_range(0, 24) != 0);
            cyc(nd, nr);
        end
        repeat (4) cyc(4'h0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pdet
